// File: rtl/shift_register_universal.sv
// Universal shift register: bidirectional serial shift, parallel load and hold,
// with a shift counter that pulses word_done once per WIDTH shifts.
module shift_register_universal #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_up,
  output logic             ser_dn,
  output logic [CNT_W-1:0] count,
  output logic             word_done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_c;

  // Next-state: data path selection, then the shared up/down shift counter
  always_comb begin
    out_d   = out_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shift_c = 1'b0;
    if (ena) begin
      case (mode)
        MODE_UP: begin
          out_d   = {out_q[WIDTH-2:0], serial_in};
          shift_c = 1'b1;
        end
        MODE_DN: begin
          out_d   = {serial_in, out_q[WIDTH-1:1]};
          shift_c = 1'b1;
        end
        MODE_LOAD: begin
          out_d = par_in;
          cnt_d = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
    if (shift_c) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_q  <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign out       = out_q;
  assign count     = cnt_q;
  assign word_done = done_q;
  // Serial taps come straight off the register, no extra delay
  assign ser_up    = out_q[WIDTH-1];
  assign ser_dn    = out_q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=32): directed boundary scenarios
// plus random traffic, checked against a shift-count/arithmetic reference model.
module tb_shift_register_universal;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          ena = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          serial_in = 1'b0;
  logic [W-1:0]  par_in = '0;
  logic [W-1:0]  out;
  logic          ser_up, ser_dn;
  logic [5:0]    count;
  logic          word_done;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Model: register value, total shifts since last load/clear, last-cycle pulse
  bit [W-1:0] m_val;
  int         m_shifts;
  bit         m_done;

  shift_register_universal #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .clr(clr), .ena(ena), .mode(mode), .serial_in(serial_in),
    .par_in(par_in), .out(out), .ser_up(ser_up), .ser_dn(ser_dn),
    .count(count), .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = '0;
    m_shifts = 0;
    m_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"}, out, m_val);
    chk({tag, "_count"}, W'(count), W'(m_shifts % W));
    chk({tag, "_done"}, W'(word_done), W'(m_done));
    chk({tag, "_serup"}, W'(ser_up), W'(m_val >> (W - 1)));
    chk({tag, "_serdn"}, W'(ser_dn), W'(m_val % 2));
  endtask

  // One clock of stimulus; model updated from the rules, then outputs checked
  task automatic step(input string tag, input logic e, input logic [1:0] md,
                      input logic s, input logic [W-1:0] p);
    @(negedge clk);
    ena = e; mode = md; serial_in = s; par_in = p;
    @(posedge clk);
    if (e === 1'b1 && md == 2'b11) begin
      m_val = p; m_shifts = 0; m_done = 1'b0;
    end else if (e === 1'b1 && (md == 2'b01 || md == 2'b10)) begin
      if (md == 2'b01) m_val = (m_val * 2) + W'(s);
      else             m_val = (m_val / 2) + (W'(s) << (W - 1));
      m_shifts++;
      m_done = (m_shifts % W) == 0;
    end else begin
      m_done = 1'b0;
    end
    #1;
    if (word_done === 1'b1) pulses++;
    check_all(tag);
  endtask

  task automatic shifts(input string tag, input int n, input logic [1:0] md, input logic s);
    for (int i = 0; i < n; i++) step(tag, 1'b1, md, s, W'($urandom));
  endtask

  task automatic clr_pulse_mid_cycle(input string tag);
    #2 clr = 1'b1;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    ena = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    // Async reset observed before any clock edge
    model_reset();
    #2 clr = 1'b1;
    #1 check_all("t1_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ena = 1'($urandom); mode = 2'($urandom); serial_in = 1'($urandom); par_in = W'($urandom);
      @(posedge clk);
      #1 check_all("t1_held");
    end
    @(negedge clk);
    ena = 1'b0;
    clr = 1'b0;

    // Fill with ones by shifting up
    step("t2_load", 1'b1, 2'b11, 1'b0, '0);
    pulses = 0;
    shifts("t2_shift", 31, 2'b01, 1'b1);
    chk("t2_nopulse_early", W'(pulses), W'(0));
    shifts("t2_last", 1, 2'b01, 1'b1);
    chk("t2_ones", out, 32'hFFFF_FFFF);
    chk("t2_pulse", W'(word_done), W'(1));
    chk("t2_count", W'(count), W'(0));

    // Shift down four places
    step("t3_load", 1'b1, 2'b11, 1'b0, 32'h8000_0001);
    shifts("t3_shift", 4, 2'b10, 1'b0);
    chk("t3_out", out, 32'h0800_0000);
    chk("t3_count", W'(count), W'(4));
    chk("t3_serdn", W'(ser_dn), W'(0));

    // Stalls between shifts leave the count alone; unselected inputs may be X
    step("t4_load", 1'b1, 2'b11, 1'b0, W'($urandom));
    pulses = 0;
    shifts("t4_a", 20, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) step("t4_ena0", 1'b0, 2'($urandom), 1'bx, 'x);
    for (int i = 0; i < 3; i++) step("t4_hold", 1'b1, 2'b00, 1'bx, 'x);
    chk("t4_count_held", W'(count), W'(20));
    for (int i = 0; i < 12; i++) step("t4_b", 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'($urandom), 'x);
    chk("t4_pulses", W'(pulses), W'(1));
    chk("t4_count_wrap", W'(count), W'(0));

    // Load wins over the wrapping shift
    step("t5_load0", 1'b1, 2'b11, 1'b0, W'($urandom));
    pulses = 0;
    shifts("t5_shift", 31, 2'b10, 1'b0);
    step("t5_load", 1'b1, 2'b11, 1'b1, 32'hA5A5_A5A5);
    chk("t5_out", out, 32'hA5A5_A5A5);
    chk("t5_count", W'(count), W'(0));
    chk("t5_pulses", W'(pulses), W'(0));

    // Mid-word async clear discards the partial word
    shifts("t6_shift", 16, 2'b01, 1'b1);
    clr_pulse_mid_cycle("t6_clr");
    pulses = 0;
    shifts("t6_after", 32, 2'b01, 1'($urandom));
    chk("t6_pulses", W'(pulses), W'(1));

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) clr_pulse_mid_cycle("rnd_clr");
      else step("rnd", ($urandom_range(0, 9) != 0), 2'($urandom), 1'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
